fifo_ctrl: RTL and testbench

//  Upstream control stage for the 32x32 register file. Converts the file into a FIFO.

---
 rtl/fifo_ctrl_pkg.sv | 13 +
 rtl/fifo_ptr.sv | 38 +++
 rtl/fifo_ctrl.sv | 109 ++++++++++
 tb/tb_fifo_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO constants: default geometry of the 32x32 register file the
// controller drives, and the wrap helper used by the pointer registers.
package fifo_ctrl_pkg;

    localparam int DEFAULT_DEPTH        = 32;
    localparam int DEFAULT_ADDRESSWIDTH = 5;

    // Index of the last entry; pointers wrap from here back to zero.
    function automatic int lastEntry(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer register: advances by one when asked and wraps from the last
// entry to zero by explicit compare, so non-power-of-two depths work.
// ptrNext is exposed so the read side can address the file one edge early.
module fifo_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int ADDRESSWIDTH = DEFAULT_ADDRESSWIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    advance,
    output logic [ADDRESSWIDTH-1:0] ptrNext,
    output logic [ADDRESSWIDTH-1:0] ptr
);

    localparam logic [ADDRESSWIDTH-1:0] LAST_ENTRY = ADDRESSWIDTH'(lastEntry(DEPTH));

    // Next pointer value: hold, or step with wrap at the last entry.
    always_comb begin
        // NOTE: default assigned first so every path drives ptrNext and no latch is inferred.
        ptrNext = ptr;
        if (advance) begin
            ptrNext = (ptr == LAST_ENTRY) ? '0 : ptr + ADDRESSWIDTH'(1);
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: non-blocking assignment so every register samples pre-edge values.
        if (!reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptrNext;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller in front of the 32x32 register file (one-cycle registered
// read). Drives the file's writeEnable/dest/source and qualifies its dataOut
// with outValid. Optional almostFull/almostEmpty flags are built when the
// macro FIFO_CTRL_ALMOST_FLAGS_EN is defined.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int ADDRESSWIDTH = DEFAULT_ADDRESSWIDTH
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    ,
    parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2
`endif
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pushValid,
    output logic                    pushReady,
    output logic                    outValid,
    input  logic                    outReady,
    output logic                    regWriteEnable,
    output logic [ADDRESSWIDTH-1:0] regDest,
    output logic [ADDRESSWIDTH-1:0] regSource,
    output logic [ADDRESSWIDTH:0]   count,
    output logic                    full,
    output logic                    empty
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    ,
    output logic                    almostFull,
    output logic                    almostEmpty
`endif
);

    localparam int                CW          = ADDRESSWIDTH + 1;
    localparam logic [CW-1:0]     DEPTH_COUNT = CW'(DEPTH);

    logic                    pushFire;
    logic                    popFire;
    logic [CW-1:0]           countNext;
    logic [CW-1:0]           remaining;
    logic [ADDRESSWIDTH-1:0] wrPtr;
    logic [ADDRESSWIDTH-1:0] wrPtrNext;
    logic [ADDRESSWIDTH-1:0] rdPtr;
    logic [ADDRESSWIDTH-1:0] rdPtrNext;
    logic                    unusedPtrBits;

    assign full      = (count == DEPTH_COUNT);
    assign empty     = (count == '0);
    assign pushReady = !full;
    assign pushFire  = pushValid & pushReady;
    assign popFire   = outValid & outReady;

    // Writes are suppressed while reset is held so no partial transfer lands in the file.
    assign regWriteEnable = pushFire & reset;
    assign regDest        = wrPtr;
    // The file samples the new head on the same edge the pop commits.
    assign regSource      = rdPtrNext;

    // The write side only needs the current pointer and the read side only the next one.
    assign unusedPtrBits = ^{wrPtrNext, rdPtr};

    fifo_ptr #(.DEPTH(DEPTH), .ADDRESSWIDTH(ADDRESSWIDTH)) uWrPtr (
        .clock   (clock),
        .reset   (reset),
        .advance (pushFire),
        .ptrNext (wrPtrNext),
        .ptr     (wrPtr)
    );

    fifo_ptr #(.DEPTH(DEPTH), .ADDRESSWIDTH(ADDRESSWIDTH)) uRdPtr (
        .clock   (clock),
        .reset   (reset),
        .advance (popFire),
        .ptrNext (rdPtrNext),
        .ptr     (rdPtr)
    );

    // Occupancy after this edge, and entries already committed that survive this pop.
    always_comb begin
        countNext = count + CW'(pushFire) - CW'(popFire);
        remaining = count - CW'(popFire);
    end

    // Occupancy and head-valid registers; a word pushed at this edge is not yet readable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            outValid <= 1'b0;
        end else begin
            count    <= countNext;
            outValid <= (remaining != '0);
        end
    end

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    // Registered watermark flags derived from the post-edge occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            almostFull  <= 1'b0;
            almostEmpty <= 1'b1;
        end else begin
            almostFull  <= (countNext >= CW'(ALMOST_FULL_LEVEL));
            almostEmpty <= (countNext <= CW'(ALMOST_EMPTY_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl paired with a behavioural 32x32 register file
// (registered read). A queue-based reference model predicts every output;
// directed phases pin latency, fill, drain/wrap, simultaneous traffic and
// reset, followed by randomized traffic. Flag checks compile in when
// FIFO_CTRL_ALMOST_FLAGS_EN is defined.
module tb_fifo_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          pushValid;
    logic          pushReady;
    logic          outValid;
    logic          outReady;
    logic          regWriteEnable;
    logic [AW-1:0] regDest;
    logic [AW-1:0] regSource;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic [31:0]   dataIn;
    logic [31:0]   dataOut;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    logic          almostFull;
    logic          almostEmpty;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fifo_ctrl #(.DEPTH(DEPTH), .ADDRESSWIDTH(AW)) dut (
        .clock          (clock),
        .reset          (reset),
        .pushValid      (pushValid),
        .pushReady      (pushReady),
        .outValid       (outValid),
        .outReady       (outReady),
        .regWriteEnable (regWriteEnable),
        .regDest        (regDest),
        .regSource      (regSource),
        .count          (count),
        .full           (full),
        .empty          (empty)
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        ,
        .almostFull     (almostFull),
        .almostEmpty    (almostEmpty)
`endif
    );

    // Register file: synchronous write, one-cycle registered read.
    logic [31:0] mem [DEPTH];
    always @(posedge clock) begin
        if (regWriteEnable) mem[regDest] <= dataIn;
        dataOut <= mem[regSource];
    end

    // Reference model: queue of stored words plus head-visibility flag.
    logic [31:0] q[$];
    bit          mValid;
    int          mPushes;
    int          mPops;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.delete();
            mValid  = 1'b0;
            mPushes = 0;
            mPops   = 0;
        end else begin
            bit popNow;
            bit pushNow;
            popNow  = mValid && outReady;
            pushNow = pushValid && (q.size() < DEPTH);
            // Only words stored before this edge can be visible after it.
            mValid  = (q.size() - int'(popNow)) != 0;
            if (popNow) begin
                void'(q.pop_front());
                mPops++;
            end
            if (pushNow) begin
                q.push_back(dataIn);
                mPushes++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model, half a cycle after each edge.
    always @(negedge clock) begin
        if (reset) begin
            check("count", 64'(count), 64'(q.size()));
            check("empty", 64'(empty), 64'(q.size() == 0));
            check("full", 64'(full), 64'(q.size() == DEPTH));
            check("pushReady", 64'(pushReady), 64'(q.size() != DEPTH));
            check("regWriteEnable", 64'(regWriteEnable), 64'(pushValid && q.size() < DEPTH));
            check("regDest", 64'(regDest), 64'(mPushes % DEPTH));
            check("regSource", 64'(regSource), 64'((mPops + int'(mValid && outReady)) % DEPTH));
            check("outValid", 64'(outValid), 64'(mValid));
            if (mValid) check("dataOut", 64'(dataOut), 64'(q[0]));
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
            check("almostFull", 64'(almostFull), 64'(q.size() >= DEPTH - 2));
            check("almostEmpty", 64'(almostEmpty), 64'(q.size() <= 2));
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit pv, input logic [31:0] d, input bit ordy);
        pushValid = pv;
        dataIn    = d;
        outReady  = ordy;
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_empty"}, 64'(empty), 64'd1);
        check({tag, "_full"}, 64'(full), 64'd0);
        check({tag, "_pushReady"}, 64'(pushReady), 64'd1);
        check({tag, "_outValid"}, 64'(outValid), 64'd0);
        check({tag, "_regWriteEnable"}, 64'(regWriteEnable), 64'd0);
    endtask

    initial begin
        bit fired;
        reset = 1'b0;
        drive(1, 32'h1234_5678, 0);
        #2;
        checkResetState("rst_init");
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        drive(0, 0, 0);
        tick();

        // Latency: push into empty at edge N, visible after edge N+1.
        drive(1, 32'hA5A5_0001, 0);
        tick();
        drive(0, 0, 0);
        check("lat_valid_n", 64'(outValid), 64'd0);
        check("lat_count_n", 64'(count), 64'd1);
        tick();
        check("lat_valid_n1", 64'(outValid), 64'd1);
        check("lat_data", 64'(dataOut), 64'hA5A5_0001);
        drive(0, 0, 1);
        tick();
        check("lat_drained", 64'(outValid), 64'd0);
        drive(0, 0, 0);

        // Fill 0..31 with the consumer stalled.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'(i), 0);
            tick();
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
            if (i == 28) check("af_29", 64'(almostFull), 64'd0);
            if (i == 29) check("af_30", 64'(almostFull), 64'd1);
`endif
        end
        check("fill_count", 64'(count), 64'd32);
        check("fill_full", 64'(full), 64'd1);
        check("fill_pushReady", 64'(pushReady), 64'd0);
        drive(1, 32'hDEAD_BEEF, 0);
        #1;
        check("fill_33rd_we", 64'(regWriteEnable), 64'd0);
        tick();
        check("fill_33rd_count", 64'(count), 64'd32);

        // Drain 32 words; the first cycle also offers a push while full.
        for (int i = 0; i < DEPTH; i++) begin
            drive(i == 0, 32'hDEAD_BEEF, 1);
            #1;
            check("drain_valid", 64'(outValid), 64'd1);
            check("drain_data", 64'(dataOut), 64'(i));
            if (i == 0) check("full_pop_push_we", 64'(regWriteEnable), 64'd0);
            tick();
            if (i == 0) check("full_pop_push_count", 64'(count), 64'd31);
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
            if (i == 28) check("ae_3", 64'(almostEmpty), 64'd0);
            if (i == 29) check("ae_2", 64'(almostEmpty), 64'd1);
`endif
        end
        check("drain_empty", 64'(empty), 64'd1);
        check("drain_outValid", 64'(outValid), 64'd0);
        check("wrap_dest", 64'(regDest), 64'd1);

        // Five more push/pop cycles across the wrapped pointers.
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h100 + 32'(k), 1);
            tick();
        end
        drive(0, 0, 1);
        repeat (3) tick();
        check("wrap_count", 64'(count), 64'd0);

        // Simultaneous push and pop with three entries stored.
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h200 + 32'(k), 0);
            tick();
        end
        drive(0, 0, 0);
        tick();
        check("sim_pre_valid", 64'(outValid), 64'd1);
        for (int c = 0; c < 20; c++) begin
            drive(1, 32'h300 + 32'(c), 1);
            tick();
            check("sim_count", 64'(count), 64'd3);
        end
        drive(0, 0, 0);
        #1;
        check("sim_head", 64'(dataOut), 64'h311);
        drive(0, 0, 1);
        repeat (5) tick();

        // Randomized traffic with alternating push-heavy and pop-heavy phases.
        fired = 1'b0;
        drive(0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            int pPush;
            int pPop;
            pPush = ((c / 300) % 2 == 0) ? 80 : 30;
            pPop  = ((c / 300) % 2 == 0) ? 30 : 80;
            if (!(pushValid && !fired)) begin
                pushValid = ($urandom_range(99) < pPush);
                dataIn    = $urandom;
            end
            outReady = ($urandom_range(99) < pPop);
            if (c == 2500) begin
                // Reset asserted mid-traffic with a push still offered.
                pushValid = 1'b1;
                #2 reset = 1'b0;
                #1;
                checkResetState("rst_mid");
                @(posedge clock);
                #2 reset = 1'b1;
                pushValid = 1'b0;
            end
            fired = pushValid && pushReady;
            tick();
        end

        drive(0, 0, 0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
